// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between the upstream word source and the serializer.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 36
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             sof;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, sof, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, sof, busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: MSB-first bit stream with a one-word holding
// register so consecutive words leave with no idle bit between them.
module seq_serializer #(
    parameter int unsigned WIDTH    = 36,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seq_serializer_if.slave    bus
);
    localparam int unsigned    CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shift_reg, shift_nxt;
    logic [WIDTH-1:0]   hold_reg, hold_nxt;
    logic               hold_full, hold_full_nxt;
    logic [CNT_W-1:0]   bit_cnt, cnt_nxt;

    logic               dout_q, dout_nxt;
    logic               dout_valid_q, dout_valid_nxt;
    logic               sof_q, sof_nxt;
    logic               busy_q, busy_nxt;
    logic               accept;

    assign bus.in_ready   = !hold_full && !rst;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sof        = sof_q;
    assign bus.busy       = busy_q;
    assign accept         = bus.in_valid && bus.in_ready;

    // State and output registers; outputs are precomputed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            bit_cnt      <= '0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift_reg    <= shift_nxt;
            hold_reg     <= hold_nxt;
            hold_full    <= hold_full_nxt;
            bit_cnt      <= cnt_nxt;
            dout_q       <= dout_nxt;
            dout_valid_q <= dout_valid_nxt;
            sof_q        <= sof_nxt;
            busy_q       <= busy_nxt;
        end
    end

    // Next-state: load, shift, reload from hold or bypass on the last bit.
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        hold_nxt      = hold_reg;
        hold_full_nxt = hold_full;
        cnt_nxt       = bit_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_nxt = bus.in_data;
                    cnt_nxt   = LAST_CNT;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shift_nxt = shift_reg << 1;
                    cnt_nxt   = bit_cnt - CNT_W'(1);
                    if (accept) begin
                        hold_nxt      = bus.in_data;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    shift_nxt     = hold_reg;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = LAST_CNT;
                end else if (accept) begin
                    shift_nxt = bus.in_data;
                    cnt_nxt   = LAST_CNT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        dout_valid_nxt = (state_nxt == SHIFT);
        dout_nxt       = dout_valid_nxt ? shift_nxt[WIDTH-1] : IDLE_BIT;
        sof_nxt        = dout_valid_nxt && (cnt_nxt == LAST_CNT);
        busy_nxt       = dout_valid_nxt || hold_full_nxt;
    end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial front end that feeds the bit-serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on dout, together with a per-bit valid and a start-of-word marker. A one-word holding register lets words stream back-to-back with no idle bit between them. The detector's din is driven from dout.

Parameters:
WIDTH, 36, word length in bits (>=2)
IDLE_BIT, 1'b0, value driven on dout when no word is being shifted

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
in_data  input  WIDTH  parallel word; sampled only on an accept
in_valid  input  1  upstream offers in_data
in_ready  output  1  block can take a word this cycle
dout  output  1  serial bit to detector din, MSB first
dout_valid  output  1  dout carries a word bit this cycle
sof  output  1  high while dout carries bit WIDTH-1 of a word
busy  output  1  word shifting or held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it is sampled only at the rising edge.
- State: shift_reg[WIDTH-1:0], bit_cnt (clog2(WIDTH) bits), hold_reg[WIDTH-1:0], hold_full, FSM state {IDLE, SHIFT}. All are registered.
- Outputs are registered:
  - dout = shift_reg[WIDTH-1] in SHIFT, IDLE_BIT in IDLE.
  - dout_valid = (state==SHIFT).
  - sof = SHIFT && bit_cnt==WIDTH-1.
  - busy = SHIFT || hold_full.
- in_ready = !hold_full && !rst (combinational). Accept = in_valid && in_ready at a rising edge.
- Reset (rst=1 at an edge):
  - state<=IDLE, hold_full<=0, bit_cnt<=0, shift_reg<=0.
  - Next cycle: dout=IDLE_BIT, dout_valid=0, sof=0, busy=0, in_ready=1.
  - Reset mid-word discards both the shifting word and the held word. No partial bits are emitted afterwards.
- IDLE:
  - On accept: shift_reg<=in_data, bit_cnt<=WIDTH-1, state<=SHIFT.
  - Latency is 1: the MSB appears on dout in the cycle after the accept edge, with sof=1.
  - hold_reg is unused in IDLE.
- SHIFT, bit_cnt>0:
  - Each edge: shift_reg<=shift_reg<<1, bit_cnt<=bit_cnt-1.
  - An accept here writes hold_reg<=in_data, hold_full<=1.
- SHIFT, bit_cnt==0 (last bit on dout), at the edge:
  - hold_full=1: shift_reg<=hold_reg, hold_full<=0, bit_cnt<=WIDTH-1, stay SHIFT. No accept is possible because in_ready=0.
  - hold_full=0 and accept: bypass, shift_reg<=in_data, bit_cnt<=WIDTH-1, stay SHIFT.
  - hold_full=0 and no accept: state<=IDLE.
  - In every case the next word's MSB follows the last bit with zero gap.
- Exactly WIDTH dout_valid cycles per accepted word. Words emerge in accept order; none is dropped or duplicated.
- in_valid is ignored while in_ready=0. in_data is ignored (may be X) when no accept occurs.
- At most two words are in flight: one shifting, one held.
- No combinational path from in_valid or in_data to any output.

Test Plan:
1. rst high 2 cycles, then accept 36'h0C269B21D (0000_1100_0010_0110_1001_1011_0010_0001_1101) -> dout reproduces those 36 bits MSB-first on consecutive cycles. dout_valid is high exactly 36 cycles, sof is high only on the first. Then dout=0, dout_valid=0, busy=0.
2. in_valid held high with words A=36'hFFFFFFFFF, B=36'h000000001 -> A is accepted at edge 0 and B at edge 1. in_ready is 0 from cycle 2 until A's last-bit edge. There are 72 consecutive dout_valid cycles, sof is at cycles 1 and 37, and dout bit 72 is 1.
3. Word offered exactly on A's last-bit cycle with hold empty -> bypass load. No dout_valid gap, sof=1 the next cycle, hold_full stays 0.
4. rst asserted while bit 10 of a word is on dout and a second word is held -> next cycle dout_valid=0, dout=IDLE_BIT, busy=0, in_ready=1. Neither word's remaining bits ever appear.
5. WIDTH=4, IDLE_BIT=1 instance, accept 4'b1011 -> dout 1,0,1,1 with dout_valid=1, then dout=1 with dout_valid=0. sof only on the first bit.
6. in_valid pulses while in_ready=0 with differing in_data -> those words are ignored; the output stream contains only the accepted words, in order.
